// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

   localparam int MAX_LEN_DEF = 8;
   localparam int CNT_W_DEF   = 8;

   localparam logic [MAX_LEN_DEF-1:0] RST_PATTERN_DEF = 8'b0000_1001;
   localparam int                     RST_LEN_DEF     = 4;
   localparam bit                     RST_OVERLAP_DEF = 1'b1;

   // Width needed to hold a pattern length of 0..max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   // Count up on inc, stick at all-ones, clear takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore serial pattern detector with valid qualifier,
// overlap/non-overlap mode, saturating match counter and sticky config error.
module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = MAX_LEN_DEF,
   parameter int                 CNT_W       = CNT_W_DEF,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = RST_PATTERN_DEF,
   parameter int                 RST_LEN     = RST_LEN_DEF,
   parameter bit                 RST_OVERLAP = RST_OVERLAP_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in,
   input  logic                        in_valid,
   input  logic                        cfg_load,
   input  logic [MAX_LEN-1:0]          cfg_pattern,
   input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
   input  logic                        cfg_overlap,
   input  logic                        clear_count,
   output logic                        out,
   output logic [CNT_W-1:0]            match_count,
   output logic [len_w(MAX_LEN)-1:0]   fill,
   output logic                        cfg_err
);

   localparam int LW = len_w(MAX_LEN);

   // The oldest history bit is never compared (only fill_n bits of hist_n
   // are), so only MAX_LEN-1 bits need storing; hist_n is the full window.
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] hist_n;
   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               ovl;

   logic [LW-1:0]      fill_n;
   logic [MAX_LEN-1:0] mask;
   logic               match;
   logic               cfg_ok;
   logic               hit;

   // Next history window, saturated fill and masked compare against the pattern.
   always_comb begin
      hist_n = {hist, in};
      fill_n = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
      mask   = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < 32'(len));
      end
      match  = (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
      cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
      hit    = !cfg_load && in_valid && match;
   end

   // Detector state, shadow configuration and registered match flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist    <= '0;
         fill    <= '0;
         out     <= 1'b0;
         cfg_err <= 1'b0;
         pat     <= RST_PATTERN;
         len     <= LW'(RST_LEN);
         ovl     <= RST_OVERLAP;
      end else if (cfg_load) begin
         fill <= '0;
         out  <= 1'b0;
         if (cfg_ok) begin
            pat <= cfg_pattern;
            len <= cfg_len;
            ovl <= cfg_overlap;
         end else begin
            cfg_err <= 1'b1;
         end
      end else if (in_valid) begin
         hist <= hist_n[MAX_LEN-2:0];
         out  <= match;
         fill <= (match && !ovl) ? '0 : fill_n;
      end else begin
         out <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear_count),
      .inc     (hit),
      .q       (match_count)
   );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed scenarios plus a random
// phase, all checked against a queue-based model of the matching rules.
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LW      = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               in = 1'b0;
   logic               in_valid = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LW-1:0]      cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               clear_count = 1'b0;
   logic               out;
   logic [CNT_W-1:0]   match_count;
   logic [LW-1:0]      fill;
   logic               cfg_err;

   int total = 0;
   int bad   = 0;

   // Reference model: bits usable for a match, in arrival order.
   bit       hq[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   int       m_cnt;
   bit       m_err;
   bit       m_out;

   seq_detector_prog #(
      .MAX_LEN     (MAX_LEN),
      .CNT_W       (CNT_W),
      .RST_PATTERN (8'b0000_1001),
      .RST_LEN     (4),
      .RST_OVERLAP (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in          (in),
      .in_valid    (in_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .clear_count (clear_count),
      .out         (out),
      .match_count (match_count),
      .fill        (fill),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      m_pat = 8'h09;
      m_len = 4;
      m_ovl = 1'b1;
      m_cnt = 0;
      m_err = 1'b0;
      m_out = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},   32'(out),         32'(m_out));
      chk({tag, ".fill"},  32'(fill),        32'(hq.size()));
      chk({tag, ".count"}, 32'(match_count), 32'(m_cnt));
      chk({tag, ".err"},   32'(cfg_err),     32'(m_err));
   endtask

   // One clock: drive inputs, advance the model by the rules, check outputs.
   task automatic step(input string tag, input bit b, input bit v, input bit ld,
                       input bit [7:0] cp, input int cl, input bit co, input bit clr);
      bit m;
      in          = b;
      in_valid    = v;
      cfg_load    = ld;
      cfg_pattern = cp;
      cfg_len     = LW'(cl);
      cfg_overlap = co;
      clear_count = clr;
      @(posedge clk);
      m = 1'b0;
      if (ld) begin
         hq.delete();
         m_out = 1'b0;
         if (cl >= 1 && cl <= MAX_LEN) begin
            m_pat = cp;
            m_len = cl;
            m_ovl = co;
         end else begin
            m_err = 1'b1;
         end
      end else if (v) begin
         hq.push_back(b);
         if (hq.size() > MAX_LEN) void'(hq.pop_front());
         if (hq.size() >= m_len) begin
            m = 1'b1;
            for (int k = 0; k < m_len; k++)
               if (hq[hq.size() - 1 - k] != m_pat[k]) m = 1'b0;
         end
         m_out = m;
         if (m && !m_ovl) hq.delete();
      end else begin
         m_out = 1'b0;
      end
      if (clr) m_cnt = 0;
      else if (m && m_cnt < 255) m_cnt++;
      #1;
      check_all(tag);
   endtask

   task automatic bit_in(input string tag, input bit b);
      step(tag, b, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic load(input string tag, input bit [7:0] p, input int l, input bit o);
      step(tag, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
   endtask

   initial begin
      bit [6:0] s1001001;
      bit [7:0] a5;
      s1001001 = 7'b1001001;
      a5       = 8'hA5;

      // Reset state
      model_reset();
      #12;
      check_all("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Default config, overlapping: matches after bits 4 and 7
      for (int i = 6; i >= 0; i--) bit_in("ovl_stream", s1001001[i]);
      chk("ovl_count", 32'(match_count), 32'd2);

      // Non-overlap: single match, then fill=3
      step("clr", 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      load("cfg_novl", 8'h09, 4, 1'b0);
      for (int i = 6; i >= 0; i--) bit_in("novl_stream", s1001001[i]);
      chk("novl_count", 32'(match_count), 32'd1);
      chk("novl_fill", 32'(fill), 32'd3);

      // Gaps in valid are ignored
      load("cfg_gap", 8'h09, 4, 1'b1);
      bit_in("gap_b1", 1'b1);
      bit_in("gap_b2", 1'b0);
      for (int i = 0; i < 3; i++) idle("gap_idle");
      bit_in("gap_b3", 1'b0);
      bit_in("gap_b4", 1'b1);
      chk("gap_match", 32'(out), 32'd1);
      idle("gap_after");

      // Illegal lengths are rejected, sticky error
      load("cfg_len0", 8'hFF, 0, 1'b1);
      chk("err_len0", 32'(cfg_err), 32'd1);
      for (int i = 3; i >= 0; i--) bit_in("old_pat", s1001001[i]);
      chk("old_pat_match", 32'(out), 32'd1);
      load("cfg_len9", 8'hFF, 9, 1'b1);
      load("cfg_a5", 8'hA5, 8, 1'b1);
      for (int i = 7; i >= 0; i--) bit_in("a5_stream", a5[i]);
      chk("a5_match", 32'(out), 32'd1);
      chk("err_sticky", 32'(cfg_err), 32'd1);

      // Counter saturation with len-1 pattern '1'
      load("cfg_len1", 8'h01, 1, 1'b0);
      for (int i = 0; i < 260; i++) bit_in("sat", 1'b1);
      chk("sat_255", 32'(match_count), 32'd255);
      step("clr_on_match", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      chk("clr_priority", 32'(match_count), 32'd0);
      bit_in("after_clr", 1'b1);
      chk("count_one", 32'(match_count), 32'd1);

      // Async reset mid-stream
      load("cfg_mid", 8'h09, 4, 1'b1);
      bit_in("mid_b1", 1'b1);
      bit_in("mid_b2", 1'b0);
      bit_in("mid_b3", 1'b0);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_fill", 32'(fill), 32'd0);
      chk("async_out", 32'(out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bit_in("lone_1", 1'b1);
      chk("lone_nomatch", 32'(out), 32'd0);
      bit_in("rst_b2", 1'b0);
      bit_in("rst_b3", 1'b0);
      bit_in("rst_b4", 1'b1);
      chk("rst_match", 32'(out), 32'd1);

      // Random phase
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3)
            load("rnd_cfg", 8'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
         else if (r < 6)
            load("rnd_cfg_short", 8'($urandom), int'($urandom_range(1, 3)), 1'($urandom));
         else
            step("rnd", 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 0,
                 1'b0, ($urandom_range(0, 49) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, runtime-programmable Moore-style serial bit-pattern detector.
- Successor to the fixed 4-bit "1001" detector. Pattern value, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loadable at runtime.
- Adds a valid qualifier on the serial input and a saturating match counter.
- Sits on a serial bitstream front-end; `out` feeds downstream frame/sync logic, `match_count` feeds status registers.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 8, match counter width.
- RST_PATTERN, 8'b0000_1001, pattern loaded at reset, MAX_LEN bits wide.
- RST_LEN, 4, pattern length at reset (1..MAX_LEN).
- RST_OVERLAP, 1, overlap mode at reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in  in  1  serial data bit.
- in_valid  in  1  `in` is sampled only when high.
- cfg_load  in  1  one-cycle pulse: capture cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  new pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- clear_count  in  1  synchronous clear of match_count.
- out  out  1  registered match flag, high for one cycle per match.
- match_count  out  CNT_W  saturating number of matches.
- fill  out  $clog2(MAX_LEN+1)  number of valid history bits (the detector's state).
- cfg_err  out  1  sticky: an illegal cfg_len was rejected.

Behaviour:
- Reset (async assert, sync-release safe):
  - hist=0, fill=0, out=0, match_count=0, cfg_err=0.
  - Active config = RST_PATTERN / RST_LEN / RST_OVERLAP.
- State:
  - hist: MAX_LEN-bit shift register.
  - fill: 0..MAX_LEN, saturates at MAX_LEN.
  - Shadow config registers: pat, len, ovl.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], in}.
  - fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0]).
- On each accepted bit:
  - hist <= hist_n; out <= match.
  - If match and ovl=0: fill <= 0 (history discarded, no bit reused). Otherwise fill <= fill_n.
- in_valid=0: hist and fill hold; out <= 0.
- Moore timing:
  - out is high in the cycle after the edge that samples the final pattern bit.
  - Latency is 1 clk. out is never combinational from `in`.
- match_count:
  - +1 on each edge where out is loaded with 1.
  - Saturates at 2^CNT_W-1.
  - clear_count has priority over increment. clear with a simultaneous match gives 0.
- cfg_load (priority over an accepted bit that cycle; that bit is dropped):
  - Legal cfg_len (1..MAX_LEN): pat/len/ovl updated; fill <= 0; out <= 0; match_count unchanged.
  - Illegal cfg_len (0 or >MAX_LEN): config unchanged, cfg_err <= 1. fill and out are still cleared.
- cfg_err clears only on reset.
- Reset mid-stream: all history lost immediately (async). The first match after release needs len fresh accepted bits.
- len=1: every accepted bit equal to pat[0] matches. With ovl=0, fill returns to 0 each match, which is functionally identical to ovl=1.
- Unused pat bits above len-1 are ignored in the compare.

Decomposition:
- Package seq_det_pkg:
  - MAX_LEN_DEF, CNT_W_DEF.
  - Length-width function clog2(MAX_LEN+1).
  - Reset-config constants.
- Sub-module sat_counter (CNT_W; ports clk, reset_n, clr, inc, q) for match_count; reused by status blocks.
- Masked-compare logic stays inline.

Test Plan:
- Reset config (1001, len 4, ovl 1); stream 1,0,0,1,0,0,1 all valid -> out high 1 clk after bit 4 and after bit 7; match_count=2.
- cfg_load pattern 1001, len 4, ovl 0; same stream 1001001 -> single match after bit 4; bits 5-7 give fill=3, no match; match_count=1.
- Stream 1,0,[valid=0 for 3 clk],0,1 -> gaps ignored; one match 1 clk after last valid bit; out low during gaps.
- cfg_load len 0 -> cfg_err=1, pattern still 1001; then cfg_load len 9 (MAX_LEN=8) -> cfg_err stays 1; len 8 pattern 8'hA5 on stream A5 MSB-first -> match after 8th bit.
- Force match_count to 255 via repeated len-1 pattern 1 with all-ones input -> holds at 255. clear_count on a match cycle -> 0. Next match -> 1.
- Assert reset_n low after bits 1,0,0 of 1001 -> fill=0 and out=0 immediately. After release, a lone `1` gives no match; full 1001 gives a match.
